// File: rtl/sign_replacer_multi_if.sv
// FIFO-side handshake bundle for sign_replacer_multi: video/token/payload read ports,
// output FIFO write port, and the global enable/mode controls.
interface sign_replacer_multi_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
);
    logic              clk_en;
    logic              mode;
    logic [DATA_W-1:0] vid_in;
    logic              vid_empty;
    logic              vid_rd;
    logic [CNT_W:0]    tok_in;
    logic              tok_empty;
    logic              tok_rd;
    logic              pay_in;
    logic              pay_empty;
    logic              pay_rd;
    logic              out_afull;
    logic [DATA_W-1:0] data_out;
    logic              data_wr;
    logic              ext_bit;
    logic              ext_wr;
    logic              last_pay_out;

    modport master (
        output clk_en, mode, vid_in, vid_empty, tok_in, tok_empty, pay_in, pay_empty, out_afull,
        input  vid_rd, tok_rd, pay_rd, data_out, data_wr, ext_bit, ext_wr, last_pay_out
    );

    modport slave (
        input  clk_en, mode, vid_in, vid_empty, tok_in, tok_empty, pay_in, pay_empty, out_afull,
        output vid_rd, tok_rd, pay_rd, data_out, data_wr, ext_bit, ext_wr, last_pay_out
    );
endinterface

// File: rtl/sign_replacer_multi.sv
// Merges a video word stream with {P,S} skip/act tokens: skips S bits, then embeds a payload
// bit (EMBED) or copies the bit out (EXTRACT). One segment is processed per enabled cycle.
module sign_replacer_multi #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
) (
    input logic clk,
    input logic rst,
    sign_replacer_multi_if.slave bus
);
    localparam int PTR_W = $clog2(DATA_W);
    localparam int LW    = (CNT_W > PTR_W + 1) ? CNT_W : PTR_W + 1;

    logic              en;
    logic              mode_q;

    logic [DATA_W-1:0] word_q;
    logic              word_v, vid_pend;
    logic [CNT_W-1:0]  s_q;
    logic              p_q, tok_v, tok_pend;
    logic              pay_q, pay_v, pay_pend;
    logic [PTR_W-1:0]  ptr_q;

    logic [DATA_W-1:0] data_q;
    logic              data_wr_q, ext_wr_q, ext_bit_q, last_q;

    logic              word_ok, tok_ok, pay_ok;
    logic [DATA_W-1:0] cur_word;
    logic [CNT_W-1:0]  cur_s;
    logic              cur_p, cur_pay;
    logic [LW-1:0]     left_w, s_w;

    logic              adv, word_done, tok_done, act, pay_use;
    logic [DATA_W-1:0] nxt_word;
    logic [PTR_W-1:0]  nxt_ptr, act_idx;
    logic [CNT_W-1:0]  nxt_s;

    assign en = bus.clk_en & ~bus.out_afull;

    // Data read on the previous cycle is used straight off the FIFO port, so a slot
    // freed this cycle can be refilled and consumed on the very next one.
    assign word_ok  = word_v | vid_pend;
    assign cur_word = vid_pend ? bus.vid_in : word_q;
    assign tok_ok   = tok_v | tok_pend;
    assign cur_s    = tok_pend ? bus.tok_in[CNT_W-1:0] : s_q;
    assign cur_p    = tok_pend ? bus.tok_in[CNT_W] : p_q;
    assign pay_ok   = pay_v | pay_pend;
    assign cur_pay  = pay_pend ? bus.pay_in : pay_q;

    assign left_w = LW'(ptr_q) + LW'(1);
    assign s_w    = LW'(cur_s);

    always_comb begin
        adv       = 1'b0;
        word_done = 1'b0;
        tok_done  = 1'b0;
        act       = 1'b0;
        pay_use   = 1'b0;
        nxt_word  = cur_word;
        nxt_ptr   = ptr_q;
        nxt_s     = cur_s;
        act_idx   = ptr_q - PTR_W'(cur_s);
        if (word_ok && tok_ok) begin
            if (s_w >= left_w) begin
                // Skip runs to (or past) the end of the word: emit it and carry the rest.
                adv       = 1'b1;
                word_done = 1'b1;
                nxt_s     = CNT_W'(s_w - left_w);
                nxt_ptr   = '1;
                tok_done  = (nxt_s == '0) && !cur_p;
            end else if (cur_p) begin
                if (mode_q || pay_ok) begin
                    adv       = 1'b1;
                    act       = 1'b1;
                    tok_done  = 1'b1;
                    pay_use   = !mode_q;
                    nxt_s     = '0;
                    if (!mode_q) begin
                        nxt_word[act_idx] = cur_pay;
                    end
                    word_done = (act_idx == '0);
                    nxt_ptr   = act_idx - PTR_W'(1);
                end
            end else begin
                adv      = 1'b1;
                tok_done = 1'b1;
                nxt_s    = '0;
                nxt_ptr  = ptr_q - PTR_W'(cur_s);
            end
        end
    end

    assign bus.vid_rd = en & ~bus.vid_empty & (~word_ok | word_done);
    assign bus.tok_rd = en & ~bus.tok_empty & (~tok_ok | tok_done);
    assign bus.pay_rd = en & ~mode_q & ~bus.pay_empty & (~pay_ok | pay_use);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= bus.mode;
            word_q    <= '0;
            word_v    <= 1'b0;
            vid_pend  <= 1'b0;
            s_q       <= '0;
            p_q       <= 1'b0;
            tok_v     <= 1'b0;
            tok_pend  <= 1'b0;
            pay_q     <= 1'b0;
            pay_v     <= 1'b0;
            pay_pend  <= 1'b0;
            ptr_q     <= '1;
            data_q    <= '0;
            data_wr_q <= 1'b0;
            ext_wr_q  <= 1'b0;
            ext_bit_q <= 1'b0;
            last_q    <= 1'b0;
        end else if (en) begin
            vid_pend <= bus.vid_rd;
            tok_pend <= bus.tok_rd;
            pay_pend <= bus.pay_rd;

            if (adv) begin
                word_q <= nxt_word;
                word_v <= ~word_done;
                ptr_q  <= nxt_ptr;
                s_q    <= nxt_s;
                p_q    <= cur_p;
                tok_v  <= ~tok_done;
            end else begin
                if (vid_pend) begin
                    word_q <= bus.vid_in;
                    word_v <= 1'b1;
                end
                if (tok_pend) begin
                    s_q   <= cur_s;
                    p_q   <= cur_p;
                    tok_v <= 1'b1;
                end
            end

            if (pay_use) begin
                pay_v <= 1'b0;
            end else if (pay_pend) begin
                pay_q <= bus.pay_in;
                pay_v <= 1'b1;
            end

            data_wr_q <= word_done;
            if (word_done) begin
                data_q <= nxt_word;
            end
            ext_wr_q <= act & mode_q;
            if (act & mode_q) begin
                ext_bit_q <= cur_word[act_idx];
            end
            if (act) begin
                last_q <= mode_q ? cur_word[act_idx] : cur_pay;
            end
        end
    end

    // Registered strobes are held while frozen and presented once enable returns.
    assign bus.data_out     = data_q;
    assign bus.data_wr      = data_wr_q & en;
    assign bus.ext_wr       = ext_wr_q & en;
    assign bus.ext_bit      = ext_bit_q;
    assign bus.last_pay_out = last_q;
endmodule

// File: tb/tb_sign_replacer_multi.sv
// Self-checking bench for sign_replacer_multi: FIFO models feed directed and random streams;
// expected outputs come from a flat bit-array model of the skip/act token rules.
module tb_sign_replacer_multi;
    logic clk;
    logic rst;

    sign_replacer_multi_if #(.DATA_W(8), .CNT_W(7)) bus ();

    sign_replacer_multi #(.DATA_W(8), .CNT_W(7)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [7:0] vq[$];
    logic [7:0] tq[$];
    logic       pq[$];
    logic [7:0] eq_data[$];
    logic       eq_ext[$];
    logic       exp_last;
    bit         exp_acted;
    int         exp_pay_reads;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lay all video bits end to end; each token advances a global bit cursor by S and
    // then (if P) rewrites or records the bit under the cursor.
    task automatic build_expect(input bit md);
        bit         bits[$];
        int         g;
        int         pi;
        logic [7:0] w;
        logic [7:0] t;
        bits = {};
        eq_data = {};
        eq_ext = {};
        exp_acted = 1'b0;
        exp_last = 1'b0;
        g = 0;
        pi = 0;
        foreach (vq[k]) begin
            w = vq[k];
            for (int b = 7; b >= 0; b--) bits.push_back(w[b]);
        end
        foreach (tq[k]) begin
            t = tq[k];
            g += int'(t[6:0]);
            if (g >= bits.size()) begin
                g = bits.size();
                break;
            end
            if (t[7]) begin
                if (md) begin
                    eq_ext.push_back(bits[g]);
                    exp_last = bits[g];
                end else begin
                    bits[g] = pq[pi];
                    exp_last = pq[pi];
                    pi++;
                end
                exp_acted = 1'b1;
                g++;
            end
        end
        for (int k = 0; k < g / 8; k++) begin
            w = '0;
            for (int b = 0; b < 8; b++) w = {w[6:0], bits[k*8+b]};
            eq_data.push_back(w);
        end
        exp_pay_reads = md ? 0 : pq.size();
    endtask

    task automatic run(input string name, input bit md, input int stall_pct,
                       input int pay_hold, input int afull_at);
        int  idle;
        int  pay_reads;
        bit  done;
        bit  v_rd, t_rd, p_rd;
        build_expect(md);
        rst = 1'b1;
        bus.mode = md;
        bus.clk_en = 1'b1;
        bus.out_afull = 1'b0;
        bus.vid_empty = 1'b1;
        bus.tok_empty = 1'b1;
        bus.pay_empty = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({name, ":rst_data_out"}, bus.data_out, 8'h00);
        chk({name, ":rst_strobes"}, {bus.data_wr, bus.ext_wr, bus.ext_bit, bus.last_pay_out}, 4'b0000);
        rst = 1'b0;
        idle = 0;
        pay_reads = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            bus.clk_en    = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            bus.out_afull = (stall_pct != 0) && ($urandom_range(99) < stall_pct);
            if (afull_at >= 0 && cyc >= afull_at && cyc < afull_at + 4) bus.out_afull = 1'b1;
            bus.vid_empty = (vq.size() == 0) || ((stall_pct != 0) && ($urandom_range(99) < stall_pct));
            bus.tok_empty = (tq.size() == 0) || ((stall_pct != 0) && ($urandom_range(99) < stall_pct));
            bus.pay_empty = (pq.size() == 0) || (cyc < pay_hold)
                            || ((stall_pct != 0) && ($urandom_range(99) < stall_pct));
            #3;
            if (afull_at >= 0 && cyc >= afull_at && cyc < afull_at + 4)
                chk({name, ":afull_strobes"},
                    {bus.vid_rd, bus.tok_rd, bus.pay_rd, bus.data_wr, bus.ext_wr}, 5'b00000);
            if (bus.data_wr) begin
                if (eq_data.size() > 0) chk({name, ":data_out"}, bus.data_out, eq_data.pop_front());
                else chk({name, ":extra_data_wr"}, bus.data_wr, 1'b0);
            end
            if (bus.ext_wr) begin
                if (eq_ext.size() > 0) chk({name, ":ext_bit"}, bus.ext_bit, eq_ext.pop_front());
                else chk({name, ":extra_ext_wr"}, bus.ext_wr, 1'b0);
            end
            if (md && bus.pay_rd) chk({name, ":pay_rd_extract"}, bus.pay_rd, 1'b0);
            v_rd = bus.vid_rd;
            t_rd = bus.tok_rd;
            p_rd = bus.pay_rd;
            if (p_rd) pay_reads++;
            @(posedge clk);
            #1;
            if (v_rd) bus.vid_in = vq.pop_front();
            if (t_rd) bus.tok_in = tq.pop_front();
            if (p_rd) bus.pay_in = pq.pop_front();
            if (eq_data.size() == 0 && eq_ext.size() == 0) idle++;
            if (idle >= 12) done = 1'b1;
        end
        chk({name, ":outstanding"}, eq_data.size() + eq_ext.size(), 0);
        chk({name, ":pay_reads"}, pay_reads, exp_pay_reads);
        if (exp_acted) chk({name, ":last_pay_out"}, bus.last_pay_out, exp_last);
    endtask

    task automatic gen_random(input bit md);
        int         ntok;
        int         g;
        int         np;
        logic [7:0] t;
        vq = {};
        tq = {};
        pq = {};
        ntok = $urandom_range(12, 4);
        g = 0;
        np = 0;
        for (int k = 0; k < ntok; k++) begin
            t[7]   = 1'($urandom_range(1));
            t[6:0] = ($urandom_range(7) == 0) ? 7'($urandom_range(127)) : 7'($urandom_range(9));
            if (k == 0 && t[6:0] == 7'd0) t[7] = 1'b1;
            g += int'(t[6:0]) + int'(t[7]);
            if (t[7]) np++;
            tq.push_back(t);
        end
        for (int k = 0; k < (g + 7) / 8; k++) vq.push_back(8'($urandom_range(255)));
        if (md) begin
            for (int k = 0; k < 3; k++) pq.push_back(1'($urandom_range(1)));
        end else begin
            for (int k = 0; k < np; k++) pq.push_back(1'($urandom_range(1)));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = 1'b0;
        bus.clk_en = 1'b1;
        bus.out_afull = 1'b0;
        bus.vid_in = '0;
        bus.vid_empty = 1'b1;
        bus.tok_in = '0;
        bus.tok_empty = 1'b1;
        bus.pay_in = 1'b0;
        bus.pay_empty = 1'b1;

        vq = {8'h00}; tq = {8'h83, 8'h04}; pq = {1'b1};
        run("embed_basic", 1'b0, 0, 0, -1);
        vq = {8'hFF, 8'hFF}; tq = {8'h8A, 8'h05}; pq = {1'b0};
        run("embed_span", 1'b0, 0, 0, -1);
        vq = {8'h00}; tq = {8'h87}; pq = {1'b1};
        run("embed_lsb", 1'b0, 0, 0, -1);
        vq = {8'h00}; tq = {8'h83, 8'h04}; pq = {1'b1};
        run("pay_stall", 1'b0, 0, 5, -1);
        vq = {8'hA5}; tq = {8'h80, 8'h86}; pq = {1'b1, 1'b0, 1'b1};
        run("extract_basic", 1'b1, 0, 0, -1);
        vq = {8'h00}; tq = {8'h81, 8'h00, 8'h02, 8'h83}; pq = {1'b1, 1'b1};
        run("afull_freeze", 1'b0, 0, 0, 3);
        vq = {8'hFF, 8'hFF}; tq = {8'h08, 8'h82}; pq = {1'b1};
        run("partial_word", 1'b0, 0, 0, -1);
        vq = {8'h00}; tq = {8'h08}; pq = {};
        run("after_rst", 1'b0, 0, 0, -1);

        for (int r = 0; r < 12; r++) begin
            gen_random(1'(r % 2));
            run($sformatf("rand%0d", r), 1'(r % 2), (r < 4) ? 0 : 25, 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
